// File: rtl/date_counter.sv
// date_counter: calendar day/month/year counter for 2000..2099 with optional weekday output.
//
// Ports
//   clk           sole clock, all state updates on the rising edge
//   reset         asynchronous, active-low; clears all state immediately
//   ClkDay        from the hour counter; high while hours==23, day rolls on its falling edge
//   DayOverPlus   one-cycle pulse: time-zone edit pushed hours past 23 (acts in Edit Mode)
//   DayOverMinus  one-cycle pulse: time-zone edit pushed hours below 0 (acts in Edit Mode)
//   KeyPlus       active-low one-cycle key pulse, +1 on the selected field
//   KeyMinus      active-low one-cycle key pulse, -1 on the selected field
//   EditMode      high in Edit Mode
//   screen        current screen; 1 = date screen
//   EditPos       edit hex position (6 = days, 4 = months, 1 = year tens, 0 = year units)
//   days          day of month, 1..31
//   months        month, 1..12
//   years         year offset from 2000, 0..99
//   weekday       0 = Sunday .. 6 = Saturday
//
// Configuration
//   DATE_WEEKDAY_EN  defined: weekday is a register tracking the date with one cycle of lag.
//                    undefined: weekday is tied to 0 and no weekday logic is built.

module date_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       ClkDay,
    input  logic       DayOverPlus,
    input  logic       DayOverMinus,
    input  logic       KeyPlus,
    input  logic       KeyMinus,
    input  logic       EditMode,
    input  logic [1:0] screen,
    input  logic [2:0] EditPos,
    output logic [4:0] days,
    output logic [3:0] months,
    output logic [6:0] years,
    output logic [2:0] weekday
);

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                      month_len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
            default:                   month_len = 5'd31;
        endcase
    endfunction

    logic       r_clkday_d;
    logic [4:0] r_days;
    logic [3:0] r_months;
    logic [6:0] r_years;

    logic       w_leap;
    logic [4:0] w_mlen;
    logic       w_rollover;
    logic       w_inc;
    logic       w_dec;
    logic       w_key_en;
    logic       w_kplus;
    logic       w_kminus;
    logic [4:0] w_days_n;
    logic [3:0] w_months_n;
    logic [6:0] w_years_n;
    logic [3:0] w_pm;
    logic [4:0] w_len_c;

    // Years 0..99 map to 2000..2099, where every multiple of 4 is a leap year.
    assign w_leap     = (r_years[1:0] == 2'b00);
    assign w_mlen     = month_len(r_months, w_leap);
    // Falling edge of ClkDay outside Edit Mode; edges during Edit Mode are simply lost.
    assign w_rollover = r_clkday_d & ~ClkDay & ~EditMode;
    assign w_inc      = w_rollover | (EditMode & DayOverPlus);
    assign w_dec      = EditMode & DayOverMinus;
    assign w_key_en   = EditMode & (screen == 2'd1);
    assign w_kplus    = w_key_en & ~KeyPlus;
    assign w_kminus   = w_key_en & ~KeyMinus;

    always_comb begin
        w_days_n   = r_days;
        w_months_n = r_months;
        w_years_n  = r_years;
        w_pm       = (r_months == 4'd1) ? 4'd12 : r_months - 4'd1;
        w_len_c    = 5'd31;
        if (w_inc) begin
            if (r_days >= w_mlen) begin
                w_days_n = 5'd1;
                if (r_months >= 4'd12) begin
                    w_months_n = 4'd1;
                    w_years_n  = (r_years >= 7'd99) ? 7'd0 : r_years + 7'd1;
                end else begin
                    w_months_n = r_months + 4'd1;
                end
            end else begin
                w_days_n = r_days + 5'd1;
            end
        end else if (w_dec) begin
            if (r_days <= 5'd1) begin
                // Previous month of January is December (31 days), so the current
                // year's leap flag is correct for every previous-month length.
                w_months_n = w_pm;
                w_days_n   = month_len(w_pm, w_leap);
                if (r_months == 4'd1) begin
                    w_years_n = (r_years == 7'd0) ? 7'd99 : r_years - 7'd1;
                end
            end else begin
                w_days_n = r_days - 5'd1;
            end
        end else if (w_kplus || w_kminus) begin
            // KeyPlus wins when both keys are low.
            case (EditPos)
                3'd6: begin
                    if (w_kplus) begin
                        w_days_n = (r_days >= w_mlen) ? 5'd1 : r_days + 5'd1;
                    end else begin
                        w_days_n = (r_days <= 5'd1) ? w_mlen : r_days - 5'd1;
                    end
                end
                3'd4: begin
                    if (w_kplus) begin
                        w_months_n = (r_months >= 4'd12) ? 4'd1 : r_months + 4'd1;
                    end else begin
                        w_months_n = w_pm;
                    end
                end
                3'd0: begin
                    if (w_kplus) begin
                        w_years_n = (r_years >= 7'd99) ? 7'd0 : r_years + 7'd1;
                    end else begin
                        w_years_n = (r_years == 7'd0) ? 7'd99 : r_years - 7'd1;
                    end
                end
                3'd1: begin
                    if (w_kplus) begin
                        w_years_n = (r_years >= 7'd90) ? r_years - 7'd90 : r_years + 7'd10;
                    end else begin
                        w_years_n = (r_years < 7'd10) ? r_years + 7'd90 : r_years - 7'd10;
                    end
                end
                default: ;
            endcase
            // Clamp the day into the (possibly new) month in the same update.
            w_len_c = month_len(w_months_n, (w_years_n[1:0] == 2'b00));
            if (w_days_n > w_len_c) begin
                w_days_n = w_len_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clkday_d <= 1'b0;
            r_days     <= 5'd1;
            r_months   <= 4'd1;
            r_years    <= 7'd0;
        end else begin
            r_clkday_d <= ClkDay;
            r_days     <= w_days_n;
            r_months   <= w_months_n;
            r_years    <= w_years_n;
        end
    end

    assign days   = r_days;
    assign months = r_months;
    assign years  = r_years;

`ifdef DATE_WEEKDAY_EN
    logic [2:0] r_weekday;
    logic [2:0] w_off;
    logic [7:0] w_yq;
    logic [7:0] w_wd_sum;
    logic [2:0] w_wd_next;

    always_comb begin
        case (r_months)
            4'd2:    w_off = 3'd3;
            4'd3:    w_off = 3'd3;
            4'd4:    w_off = 3'd6;
            4'd5:    w_off = 3'd1;
            4'd6:    w_off = 3'd4;
            4'd7:    w_off = 3'd6;
            4'd8:    w_off = 3'd2;
            4'd9:    w_off = 3'd5;
            4'd11:   w_off = 3'd3;
            4'd12:   w_off = 3'd5;
            default: w_off = 3'd0;
        endcase
        // Leap days of earlier years in the century: ceil(y/4).
        w_yq      = ({1'b0, r_years} + 8'd3) >> 2;
        // 6 + (d - 1) folded into 5 + d so nothing can underflow.
        w_wd_sum  = 8'd5 + {1'b0, r_years} + w_yq + {5'b0, w_off}
                  + {7'b0, (w_leap && (r_months > 4'd2))} + {3'b0, r_days};
        w_wd_next = 3'(w_wd_sum % 8'd7);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_weekday <= 3'd6;
        end else begin
            r_weekday <= w_wd_next;
        end
    end

    assign weekday = r_weekday;
`else
    assign weekday = 3'd0;
`endif

endmodule

// File: tb/tb_date_counter.sv
module tb_date_counter;

    logic       clk;
    logic       reset;
    logic       ClkDay;
    logic       DayOverPlus;
    logic       DayOverMinus;
    logic       KeyPlus;
    logic       KeyMinus;
    logic       EditMode;
    logic [1:0] screen;
    logic [2:0] EditPos;
    logic [4:0] days;
    logic [3:0] months;
    logic [6:0] years;
    logic [2:0] weekday;

    date_counter dut (
        .clk          (clk),
        .reset        (reset),
        .ClkDay       (ClkDay),
        .DayOverPlus  (DayOverPlus),
        .DayOverMinus (DayOverMinus),
        .KeyPlus      (KeyPlus),
        .KeyMinus     (KeyMinus),
        .EditMode     (EditMode),
        .screen       (screen),
        .EditPos      (EditPos),
        .days         (days),
        .months       (months),
        .years        (years),
        .weekday      (weekday)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Reference model: calendar date plus previous ClkDay sample and expected weekday.
    int   md, mm, my;
    logic mprev;
    int   exp_wd;

    typedef struct {
        logic       em;
        logic [1:0] scr;
        logic [2:0] pos;
        logic       kp;
        logic       km;
        logic       dop;
        logic       dom;
        int         d;
        int         m;
        int         y;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic em, input logic [1:0] scr, input logic [2:0] pos,
                               input logic kp, input logic km, input logic dop, input logic dom,
                               input int d, input int m, input int y);
        vec_t r;
        r.em = em; r.scr = scr; r.pos = pos; r.kp = kp; r.km = km;
        r.dop = dop; r.dom = dom; r.d = d; r.m = m; r.y = y;
        return r;
    endfunction

    function automatic int ylen(input int y);
        return (y % 4 == 0) ? 366 : 365;
    endfunction

    function automatic int mlen(input int y, input int m);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    // Days elapsed since 2000-01-01.
    function automatic int to_idx(input int y, input int m, input int d);
        int idx;
        idx = 0;
        for (int yy = 0; yy < y; yy++) idx += ylen(yy);
        for (int k = 1; k < m; k++) idx += mlen(y, k);
        return idx + d - 1;
    endfunction

    task automatic from_idx(input int idx, output int y, output int m, output int d);
        int r;
        r = idx;
        y = 0;
        while (r >= ylen(y)) begin
            r -= ylen(y);
            y++;
        end
        m = 1;
        while (r >= mlen(y, m)) begin
            r -= mlen(y, m);
            m++;
        end
        d = r + 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        check("days", int'(days), md);
        check("months", int'(months), mm);
        check("years", int'(years), my);
`ifdef DATE_WEEKDAY_EN
        check("weekday", int'(weekday), exp_wd);
`else
        check("weekday", int'(weekday), 0);
`endif
    endtask

    task automatic check_date(input string name, input int y, input int m, input int d);
        check({name, "_day"}, int'(days), d);
        check({name, "_mon"}, int'(months), m);
        check({name, "_yr"}, int'(years), y);
    endtask

    task automatic model_step();
        int idx;
        int ml;
        int dlt;
        idx    = to_idx(my, mm, md);
        exp_wd = (6 + idx) % 7;
        if ((mprev && !ClkDay && !EditMode) || (EditMode && DayOverPlus)) begin
            from_idx((idx + 1) % 36525, my, mm, md);
        end else if (EditMode && DayOverMinus) begin
            from_idx((idx + 36524) % 36525, my, mm, md);
        end else if (EditMode && screen == 2'd1 && (!KeyPlus || !KeyMinus)) begin
            dlt = (KeyPlus == 1'b0) ? 1 : -1;
            case (EditPos)
                3'd6: begin
                    ml = mlen(my, mm);
                    md = ((md - 1 + dlt + ml) % ml) + 1;
                end
                3'd4: mm = ((mm - 1 + dlt + 12) % 12) + 1;
                3'd0: my = (my + dlt + 100) % 100;
                3'd1: my = (my + 10 * dlt + 100) % 100;
                default: ;
            endcase
            ml = mlen(my, mm);
            if (md > ml) md = ml;
        end
        mprev = ClkDay;
    endtask

    // Inputs are set between edges; the edge samples them, outputs are checked 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        check_date("rst", 0, 1, 1);
`ifdef DATE_WEEKDAY_EN
        check("rst_weekday", int'(weekday), 6);
`else
        check("rst_weekday", int'(weekday), 0);
`endif
        md = 1; mm = 1; my = 0; mprev = 1'b0; exp_wd = 6;
        reset = 1'b1;
    endtask

    task automatic idle();
        KeyPlus      = 1'b1;
        KeyMinus     = 1'b1;
        DayOverPlus  = 1'b0;
        DayOverMinus = 1'b0;
    endtask

    task automatic press(input int pos, input bit up);
        EditMode = 1'b1;
        screen   = 2'd1;
        EditPos  = 3'(pos);
        if (up) KeyPlus = 1'b0;
        else    KeyMinus = 1'b0;
        cyc();
        KeyPlus  = 1'b1;
        KeyMinus = 1'b1;
    endtask

    task automatic set_date(input int y, input int m, input int d);
        int guard;
        EditMode = 1'b1;
        ClkDay   = 1'b0;
        idle();
        guard = 0;
        while (my != y && guard < 40) begin
            if (my / 10 != y / 10) press(1, 1'b1);
            else press(0, (my % 10) < (y % 10));
            guard++;
        end
        while (mm != m && guard < 80) begin
            press(4, 1'b1);
            guard++;
        end
        while (md != d && guard < 130) begin
            press(6, 1'b1);
            guard++;
        end
        check("set_date_bound", guard < 130 ? 1 : 0, 1);
        EditMode = 1'b0;
        screen   = 2'd0;
        EditPos  = 3'd0;
    endtask

    task automatic fall();
        ClkDay = 1'b1;
        cyc();
        ClkDay = 1'b0;
        cyc();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        ClkDay = 1'b0;
        EditMode = 1'b0;
        screen = 2'd0;
        EditPos = 3'd0;
        idle();
        md = 1; mm = 1; my = 0; mprev = 1'b0; exp_wd = 6;
        @(posedge clk);
        #1;
        do_reset();
        cyc();

        // Directed vectors from 2000-01-01.
        vecs.push_back(v(1, 1, 6, 0, 1, 0, 0,  2,  1, 0));
        vecs.push_back(v(1, 1, 6, 1, 0, 0, 0,  1,  1, 0));
        vecs.push_back(v(1, 1, 6, 1, 0, 0, 0, 31,  1, 0));
        vecs.push_back(v(1, 1, 4, 0, 1, 0, 0, 29,  2, 0));
        vecs.push_back(v(1, 1, 1, 0, 1, 0, 0, 28,  2, 10));
        vecs.push_back(v(1, 1, 0, 1, 0, 0, 0, 28,  2, 9));
        vecs.push_back(v(1, 1, 1, 1, 0, 0, 0, 28,  2, 99));
        vecs.push_back(v(1, 1, 0, 0, 1, 0, 0, 28,  2, 0));
        vecs.push_back(v(1, 1, 6, 0, 0, 0, 0, 29,  2, 0));
        vecs.push_back(v(1, 1, 5, 0, 1, 0, 0, 29,  2, 0));
        vecs.push_back(v(1, 0, 6, 0, 1, 0, 0, 29,  2, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 1, 0,  1,  3, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 0, 1, 29,  2, 0));
        vecs.push_back(v(1, 1, 6, 0, 1, 1, 1,  1,  3, 0));
        vecs.push_back(v(1, 1, 6, 0, 1, 0, 1, 29,  2, 0));
        vecs.push_back(v(0, 1, 6, 0, 1, 1, 0, 29,  2, 0));
        vecs.push_back(v(0, 1, 6, 1, 0, 0, 1, 29,  2, 0));
        vecs.push_back(v(1, 1, 4, 1, 0, 0, 0, 29,  1, 0));
        vecs.push_back(v(1, 1, 4, 1, 0, 0, 0, 29, 12, 0));
        vecs.push_back(v(1, 1, 4, 0, 1, 0, 0, 29,  1, 0));
        vecs.push_back(v(1, 1, 2, 0, 1, 0, 0, 29,  1, 0));
        foreach (vecs[i]) begin
            EditMode     = vecs[i].em;
            screen       = vecs[i].scr;
            EditPos      = vecs[i].pos;
            KeyPlus      = vecs[i].kp;
            KeyMinus     = vecs[i].km;
            DayOverPlus  = vecs[i].dop;
            DayOverMinus = vecs[i].dom;
            cyc();
            check_date($sformatf("vec%0d", i), vecs[i].y, vecs[i].m, vecs[i].d);
        end
        idle();

        // Rollover after a 3-cycle ClkDay pulse.
        set_date(23, 2, 28);
        ClkDay = 1'b1;
        repeat (3) cyc();
        ClkDay = 1'b0;
        cyc();
        check_date("roll_2023", 23, 3, 1);
        cyc();
`ifdef DATE_WEEKDAY_EN
        check("roll_2023_wd", int'(weekday), 3);
`endif

        // Leap February and century wrap.
        set_date(24, 2, 28);
        fall();
        check_date("leap_29", 24, 2, 29);
        fall();
        check_date("leap_mar", 24, 3, 1);
        set_date(99, 12, 31);
        fall();
        check_date("wrap_up", 0, 1, 1);

        // Time-zone day shifts across the century boundary.
        set_date(0, 1, 1);
        EditMode = 1'b1;
        DayOverMinus = 1'b1;
        cyc();
        DayOverMinus = 1'b0;
        check_date("dom_wrap", 99, 12, 31);
        DayOverPlus = 1'b1;
        cyc();
        DayOverPlus = 1'b0;
        check_date("dop_wrap", 0, 1, 1);

        // Month/year key edits with clamping.
        set_date(24, 1, 31);
        press(4, 1'b1);
        check_date("key_mon_clamp", 24, 2, 29);
        press(0, 1'b1);
        check_date("key_yr_clamp", 25, 2, 28);

        set_date(24, 1, 1);
        press(6, 1'b0);
        check_date("key_day_wrap", 24, 1, 31);

        // Fall during Edit Mode with DayOverPlus: exactly one advance.
        set_date(10, 5, 31);
        ClkDay = 1'b1;
        cyc();
        EditMode = 1'b1;
        ClkDay = 1'b0;
        DayOverPlus = 1'b1;
        cyc();
        DayOverPlus = 1'b0;
        check_date("one_adv", 10, 6, 1);
        cyc();
        check_date("one_adv_hold", 10, 6, 1);

        // Reset with a pending ClkDay fall: nothing replays after release.
        EditMode = 1'b0;
        ClkDay = 1'b1;
        cyc();
        ClkDay = 1'b0;
        do_reset();
        cyc();
        check_date("no_replay", 0, 1, 1);
`ifdef DATE_WEEKDAY_EN
        check("no_replay_wd", int'(weekday), 6);
`endif

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 255) == 0) do_reset();
            if ($urandom_range(0, 2) == 0) ClkDay = ~ClkDay;
            EditMode     = ($urandom_range(0, 1) == 1);
            screen       = ($urandom_range(0, 9) < 7) ? 2'd1 : 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       EditPos = 3'd0;
                1:       EditPos = 3'd1;
                2:       EditPos = 3'd4;
                3:       EditPos = 3'd6;
                default: EditPos = 3'($urandom_range(0, 7));
            endcase
            KeyPlus      = ($urandom_range(0, 3) != 0);
            KeyMinus     = ($urandom_range(0, 3) != 0);
            DayOverPlus  = ($urandom_range(0, 7) == 0);
            DayOverMinus = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
